// File: rtl/bsram_boot_loader.sv
// bsram_boot_loader: copies a fixed LENGTH-word image from an internal ROM into the
// Gowin SDPB block RAM at BASE_ADDR. Once the image is in place, the BSRAM read port
// is handed to the CPU. boot_busy holds the CPU off until then.
//
// Optional feature: define BOOT_VERIFY_EN to compile in a read-back verify pass.
// Without it, GAP goes straight to DONE and boot_err/err_addr stay 0.
//
// ROM contents come from INIT_IMAGE, with word i at bits [i*DATA_W +: DATA_W].
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start            pulse: start/restart the copy from IDLE, DONE or ERROR
//   cea, ada, din    BSRAM write port
//   ceb, oce, adb    BSRAM read port (boot loader during verify, CPU in DONE/ERROR)
//   dout             BSRAM read data
//   cpu_ceb, cpu_adb CPU read request
//   boot_busy        copy/verify in progress
//   boot_done        image loaded (and verified); sticky until start/reset
//   boot_err         verify mismatch; sticky until start/reset
//   err_addr         BSRAM address of the first mismatch
module bsram_boot_loader #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 13'h0200,
  parameter int unsigned LENGTH = 4,
  parameter INIT_FILE = "boot.hex",
  parameter logic [((LENGTH > 0) ? LENGTH : 1)*DATA_W-1:0] INIT_IMAGE = '0,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              cea,
  output logic [ADDR_W-1:0] ada,
  output logic [DATA_W-1:0] din,
  output logic              ceb,
  output logic              oce,
  output logic [ADDR_W-1:0] adb,
  input  logic [DATA_W-1:0] dout,
  input  logic              cpu_ceb,
  input  logic [ADDR_W-1:0] cpu_adb,
  output logic              boot_busy,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W-1:0] err_addr
);

  // idx must be able to hold LENGTH itself (the "all words issued" marker).
  localparam int unsigned IdxW = (LENGTH > 0) ? $clog2(LENGTH + 1) : 1;
  localparam logic [IdxW-1:0] LenIdx = IdxW'(LENGTH);

  typedef enum logic [2:0] {
    StIdle, StWrite, StGap, StVerify, StDrain, StDone, StError
  } state_e;

  state_e          state;
  logic [IdxW-1:0] idx;
  logic            launch;

  // ROM is sized to the full index range so any idx value is a legal subscript.
  logic [DATA_W-1:0] rom [2**IdxW];

  for (genvar i = 0; i < 2**IdxW; i++) begin : g_word
    if (i < LENGTH) begin : g_used
      assign rom[i] = INIT_IMAGE[i*DATA_W +: DATA_W];
    end else begin : g_pad
      assign rom[i] = '0;
    end
  end

  always_comb begin
    launch = 1'b0;
    if (state == StIdle) launch = AUTO_START || start;
    else if (state == StDone || state == StError) launch = start;
  end

`ifdef BOOT_VERIFY_EN
  // Read-back pipeline: a read issued at edge N is compared at edge N+3. The BSRAM
  // samples adb at N+1 and its output register updates at N+2.
  logic [2:0]      vld_q;
  logic [IdxW-1:0] pidx_q [3];
  logic            drain_q;
  logic            issue;
  logic [IdxW-1:0] issue_idx;
  logic            mismatch;

  always_comb begin
    issue     = (state == StGap) || (state == StVerify && idx != LenIdx);
    issue_idx = (state == StGap) ? '0 : idx;
    mismatch  = vld_q[2] && (dout != rom[pidx_q[2]]);
  end
`else
  logic unused_dout;
  assign unused_dout = ^dout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      idx       <= '0;
      cea       <= 1'b0;
      ada       <= '0;
      din       <= '0;
      ceb       <= 1'b0;
      oce       <= 1'b0;
      adb       <= '0;
      boot_busy <= 1'b0;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
      err_addr  <= '0;
`ifdef BOOT_VERIFY_EN
      vld_q     <= '0;
      pidx_q[0] <= '0;
      pidx_q[1] <= '0;
      pidx_q[2] <= '0;
      drain_q   <= 1'b0;
`endif
    end else begin
      cea <= 1'b0;
`ifdef BOOT_VERIFY_EN
      vld_q     <= {vld_q[1:0], issue};
      pidx_q[0] <= issue_idx;
      pidx_q[1] <= pidx_q[0];
      pidx_q[2] <= pidx_q[1];
`endif
      if (launch) begin
        boot_done <= 1'b0;
        boot_err  <= 1'b0;
        err_addr  <= '0;
        ceb       <= 1'b0;
        oce       <= 1'b0;
        adb       <= '0;
        if (LENGTH == 0) begin
          state     <= StDone;
          boot_done <= 1'b1;
        end else begin
          // First word goes out on the launch edge so writes have no leading bubble.
          state     <= StWrite;
          boot_busy <= 1'b1;
          cea       <= 1'b1;
          ada       <= BASE_ADDR;
          din       <= rom[0];
          idx       <= IdxW'(1);
        end
      end else begin
        case (state)
          StWrite: begin
            if (idx == LenIdx) begin
              state <= StGap;
            end else begin
              cea <= 1'b1;
              ada <= BASE_ADDR + ADDR_W'(idx);
              din <= rom[idx];
              idx <= idx + 1'b1;
            end
          end
`ifdef BOOT_VERIFY_EN
          StGap: begin
            state <= StVerify;
            ceb   <= 1'b1;
            oce   <= 1'b1;
            adb   <= BASE_ADDR;
            idx   <= IdxW'(1);
          end
          StVerify: begin
            if (idx == LenIdx) begin
              state   <= StDrain;
              ceb     <= 1'b0;
              drain_q <= 1'b0;
            end else begin
              ceb <= 1'b1;
              adb <= BASE_ADDR + ADDR_W'(idx);
              idx <= idx + 1'b1;
            end
          end
          StDrain: begin
            drain_q <= 1'b1;
            if (drain_q) begin
              state     <= StDone;
              boot_busy <= 1'b0;
              boot_done <= 1'b1;
            end
          end
`else
          StGap: begin
            state     <= StDone;
            boot_busy <= 1'b0;
            boot_done <= 1'b1;
          end
`endif
          StDone, StError: begin
            ceb <= cpu_ceb;
            adb <= cpu_adb;
            oce <= 1'b1;
          end
          default: ;
        endcase
      end
`ifdef BOOT_VERIFY_EN
      // A mismatch overrides whatever the state machine chose this edge.
      if (mismatch) begin
        state     <= StError;
        boot_busy <= 1'b0;
        boot_done <= 1'b0;
        boot_err  <= 1'b1;
        err_addr  <= BASE_ADDR + ADDR_W'(pidx_q[2]);
        ceb       <= 1'b0;
        vld_q     <= '0;
      end
`endif
    end
  end

endmodule
